kpscan: RTL and testbench

//  Hardware scanner for the external 4x4 keypad, replacing software column

---
 rtl/kpscan_if.sv | 22 ++
 rtl/kpscan.sv | 245 ++++++++++++++++++++++++
 tb/tb_kpscan.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/kpscan_if.sv
// Wishbone slave bus bundle for the keypad scanner.
// No logic of its own; pure wiring between bus master and kpscan.
// No backpressure: every strobe is acknowledged on the next clock.
interface kpscan_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic        i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_data
  );
endinterface

// File: rtl/kpscan.sv
// 4x4 keypad scanner: column strobe, row sync, scan debounce, event FIFO.
// Bus latency: ack and read data one clock after strobe; scan period 4*(SETTLE_CYCLES+1).
// No bus stalls; event pushed into a full FIFO is dropped and flags overflow.
module kpscan #(
  parameter int SETTLE_CYCLES  = 800,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int LGFIFO         = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  kpscan_if.slave    wb,
  output logic [3:0] o_kp_col,
  input  logic [3:0] i_kp_row,
  output logic       o_kp_int
);

  localparam int DEPTH = 1 << LGFIFO;
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW    = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0]   DB_MAX      = DW'(DEBOUNCE_SCANS);
  localparam logic [LGFIFO:0] FULL_CNT    = {1'b1, {LGFIFO{1'b0}}};

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        row_s1_q, row_s1_d;
  logic [3:0]        row_s2_q, row_s2_d;
  logic [1:0]        col_q, col_d;
  logic [SW-1:0]     set_cnt_q, set_cnt_d;
  logic [DW-1:0]     db_cnt_q, db_cnt_d;
  logic [3:0]        emit_k_q, emit_k_d;
  logic [15:0]       raw_q, raw_d;
  logic [15:0]       prev_q, prev_d;
  logic [15:0]       stable_q, stable_d;
  logic [15:0]       rep_q, rep_d;
  logic              en_q, en_d;
  logic              ovf_q, ovf_d;
  logic [4:0]        mem_q [DEPTH];
  logic [4:0]        mem_d [DEPTH];
  logic [LGFIFO-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFIFO-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGFIFO:0]   fcnt_q, fcnt_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              int_q, int_d;

  logic              push;
  logic [4:0]        push_dat;
  logic [15:0]       raw_new;
  logic [DW-1:0]     db_new;
  logic              bus_stb;
  logic              pop;
  logic              do_push;
  logic              fifo_full;
  logic              fifo_vld;
  logic              unused_ok;

  assign unused_ok = ^wb.i_wb_data[29:0];

  // Column drive follows the scan column; released while disabled or emitting.
  assign o_kp_col      = (en_q && (state_q != EMIT)) ? ~(4'b0001 << col_q) : 4'hf;
  assign o_kp_int      = int_q;
  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_data  = rdat_q;

  // Row synchronizer, scan FSM, debounce and event generation.
  always_comb begin
    row_s1_d  = i_kp_row;
    row_s2_d  = row_s1_q;
    state_d   = state_q;
    col_d     = col_q;
    set_cnt_d = set_cnt_q;
    db_cnt_d  = db_cnt_q;
    emit_k_d  = emit_k_q;
    raw_d     = raw_q;
    prev_d    = prev_q;
    stable_d  = stable_q;
    rep_d     = rep_q;
    push      = 1'b0;
    push_dat  = 5'h0;
    raw_new   = raw_q;
    db_new    = db_cnt_q;

    if (!en_q) begin
      state_d   = SETTLE;
      col_d     = 2'd0;
      set_cnt_d = '0;
      db_cnt_d  = '0;
      emit_k_d  = 4'd0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (set_cnt_q == SETTLE_LAST) begin
            set_cnt_d = '0;
            state_d   = SAMPLE;
          end else begin
            set_cnt_d = set_cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          raw_new[{col_q, 2'b00} +: 4] = ~row_s2_q;
          raw_d   = raw_new;
          col_d   = col_q + 2'd1;
          state_d = SETTLE;
          if (col_q == 2'd3) begin
            // Full snapshot captured: debounce against the previous one.
            prev_d = raw_new;
            if (raw_new == prev_q) begin
              db_new = (db_cnt_q == DB_MAX) ? DB_MAX : db_cnt_q + 1'b1;
            end else begin
              db_new = DW'(1);
            end
            db_cnt_d = db_new;
            if (db_new == DB_MAX) begin
              stable_d = raw_new;
              if (raw_new != rep_q) begin
                state_d  = EMIT;
                emit_k_d = 4'd0;
              end
            end
          end
        end
        EMIT: begin
          // Walk keys in ascending order; reported map tracks even dropped events.
          if (stable_q[emit_k_q] != rep_q[emit_k_q]) begin
            push              = 1'b1;
            push_dat          = {stable_q[emit_k_q], emit_k_q};
            rep_d[emit_k_q]   = stable_q[emit_k_q];
          end
          if (emit_k_q == 4'd15) begin
            emit_k_d = 4'd0;
            state_d  = SETTLE;
          end else begin
            emit_k_d = emit_k_q + 4'd1;
          end
        end
        default: state_d = SETTLE;
      endcase
    end
  end

  // Wishbone register access, event FIFO and interrupt.
  always_comb begin
    en_d      = en_q;
    ovf_d     = ovf_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fcnt_d    = fcnt_q;
    rdat_d    = rdat_q;
    bus_stb   = wb.i_wb_cyc & wb.i_wb_stb;
    ack_d     = bus_stb;
    fifo_vld  = (fcnt_q != '0);
    fifo_full = (fcnt_q == FULL_CNT);
    pop       = bus_stb & ~wb.i_wb_we & wb.i_wb_addr & fifo_vld;
    do_push   = push & (~fifo_full | pop);
    int_d     = en_q & fifo_vld;

    if (bus_stb) begin
      if (wb.i_wb_addr) begin
        rdat_d = {23'h0, fifo_vld, 3'h0, fifo_vld ? mem_q[rd_ptr_q] : 5'h0};
      end else begin
        rdat_d = {ovf_q, en_q, 10'h0, 4'(fcnt_q), stable_q};
      end
      if (wb.i_wb_we && !wb.i_wb_addr) begin
        en_d = wb.i_wb_data[30];
        if (wb.i_wb_data[31]) begin
          ovf_d = 1'b0;
        end
      end
    end

    // A lost event outranks a same-clock overflow clear.
    if (push && !do_push) begin
      ovf_d = 1'b1;
    end

    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      row_s1_q  <= 4'hf;
      row_s2_q  <= 4'hf;
      state_q   <= SETTLE;
      col_q     <= 2'd0;
      set_cnt_q <= '0;
      db_cnt_q  <= '0;
      emit_k_q  <= 4'd0;
      raw_q     <= 16'h0;
      prev_q    <= 16'h0;
      stable_q  <= 16'h0;
      rep_q     <= 16'h0;
      en_q      <= 1'b0;
      ovf_q     <= 1'b0;
      mem_q     <= '{default: 5'h0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
      ack_q     <= 1'b0;
      rdat_q    <= 32'h0;
      int_q     <= 1'b0;
    end else begin
      row_s1_q  <= row_s1_d;
      row_s2_q  <= row_s2_d;
      state_q   <= state_d;
      col_q     <= col_d;
      set_cnt_q <= set_cnt_d;
      db_cnt_q  <= db_cnt_d;
      emit_k_q  <= emit_k_d;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      rep_q     <= rep_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
      ack_q     <= ack_d;
      rdat_q    <= rdat_d;
      int_q     <= int_d;
    end
  end

endmodule

// File: tb/tb_kpscan.sv
// Self-checking bench for kpscan with a keypad model and an event-level reference.
// Bus transfers take one clock; key changes are given ample scan time to settle.
// Bench never stalls the DUT; all waits are cycle-bounded.
module tb_kpscan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  kp_col;
  logic [3:0]  kp_row;
  logic        kp_int;
  logic [15:0] keys;
  logic        chk_on;
  logic        exp_ack;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  // Reference state: what the CPU should observe.
  bit          m_en;
  bit          m_ovf;
  logic [15:0] m_stable;
  logic [15:0] m_rep;
  logic [4:0]  m_q [$];

  kpscan_if wb ();

  kpscan #(
    .SETTLE_CYCLES (3),
    .DEBOUNCE_SCANS(2),
    .LGFIFO        (2)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .wb        (wb),
    .o_kp_col  (kp_col),
    .i_kp_row  (kp_row),
    .o_kp_int  (kp_int)
  );

  always #5 clk = ~clk;

  // Passive keypad matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    kp_row = 4'hf;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !kp_col[c]) kp_row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_accept(input logic [15:0] nm);
    m_stable = nm;
    for (int k = 0; k < 16; k++) begin
      if (nm[k] != m_rep[k]) begin
        if (m_q.size() < 4) m_q.push_back({nm[k], 4'(k)});
        else m_ovf = 1'b1;
        m_rep[k] = nm[k];
      end
    end
  endfunction

  function automatic logic [31:0] model_status();
    return {m_ovf, m_en, 10'h0, 4'(m_q.size()), m_stable};
  endfunction

  function automatic logic [31:0] model_pop();
    logic [4:0] e;
    if (m_q.size() == 0) return 32'h0;
    e = m_q.pop_front();
    return {23'h0, 1'b1, 3'h0, e};
  endfunction

  function automatic void model_reset();
    m_en = 1'b0; m_ovf = 1'b0; m_stable = 16'h0; m_rep = 16'h0;
    m_q.delete();
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic addr, input logic [31:0] wd,
                         output logic [31:0] rdat);
    wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = we;
    wb.i_wb_addr = addr; wb.i_wb_data = wd;
    @(posedge clk); #1;
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
    check("ack_next_clk", {31'h0, wb.o_wb_ack}, 32'h1);
    rdat = wb.o_wb_data;
  endtask

  task automatic wait_col(input int c);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << c);
    n = 0;
    while (kp_col == tgt && n < 200) begin cycles(1); n++; end
    while (kp_col != tgt && n < 200) begin cycles(1); n++; end
    check("col_wait_in_budget", {31'h0, n < 200}, 32'h1);
  endtask

  // Expected ack is the previous clock's strobe.
  always @(posedge clk)
    exp_ack <= rst_n ? (wb.i_wb_cyc & wb.i_wb_stb) : 1'b0;

  // Per-cycle checks on the bus handshake and the column drive.
  always @(negedge clk) begin
    if (chk_on) begin
      check("ack_pulse", {31'h0, wb.o_wb_ack}, {31'h0, exp_ack});
      if (!m_en) check("col_idle", {28'h0, kp_col}, 32'hf);
      else check("col_one_cold", {31'h0, (kp_col == 4'hf) || $onehot(~kp_col)}, 32'h1);
    end
  end

  initial begin
    chk_on = 1'b0;
    rst_n  = 1'b0;
    keys   = 16'h0;
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
    wb.i_wb_addr = 1'b0; wb.i_wb_data = 32'h0;
    model_reset();
    cycles(3);
    check("rst_col", {28'h0, kp_col}, 32'hf);
    check("rst_ack", {31'h0, wb.o_wb_ack}, 32'h0);
    check("rst_data", wb.o_wb_data, 32'h0);
    check("rst_int", {31'h0, kp_int}, 32'h0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    cycles(1);
    wb_xfer(1'b0, 1'b0, 32'h0, rd);
    check("status_after_reset", rd, model_status());

    // Enable scanning.
    wb_xfer(1'b1, 1'b0, 32'h4000_0000, rd);
    m_en = 1'b1;
    wb_xfer(1'b0, 1'b0, 32'h0, rd);
    check("status_enabled", rd, model_status());

    // Single press: row2 in column1 -> key 6.
    keys = 16'h0040;
    cycles(150);
    model_accept(keys);
    check("int_on_press", {31'h0, kp_int}, {31'h0, m_en && m_q.size() > 0});
    wb_xfer(1'b0, 1'b0, 32'h0, rd);
    check("status_press", rd, model_status());
    check("status_press_lit", rd, 32'h4001_0040);
    wb_xfer(1'b0, 1'b1, 32'h0, rd);
    check("ev_press", rd, model_pop());
    check("ev_press_lit", rd, 32'h0000_0116);
    cycles(2);
    check("int_after_pop", {31'h0, kp_int}, {31'h0, m_en && m_q.size() > 0});

    // Release.
    keys = 16'h0;
    cycles(150);
    model_accept(keys);
    wb_xfer(1'b0, 1'b1, 32'h0, rd);
    check("ev_release", rd, model_pop());
    check("ev_release_lit", rd, 32'h0000_0106);
    wb_xfer(1'b0, 1'b0, 32'h0, rd);
    check("status_release", rd, model_status());

    // One-scan glitch on key 9 (column 2, row 1): nothing must be reported.
    wait_col(2);
    keys = 16'h0200;
    cycles(8);
    keys = 16'h0;
    cycles(150);
    wb_xfer(1'b0, 1'b0, 32'h0, rd);
    check("status_glitch", rd, model_status());
    check("status_glitch_lit", rd, 32'h4000_0000);
    check("int_glitch", {31'h0, kp_int}, 32'h0);

    // Five keys at once overflow a 4-entry FIFO; highest key is lost.
    keys = 16'h8461;
    cycles(150);
    model_accept(keys);
    wb_xfer(1'b0, 1'b0, 32'h0, rd);
    check("status_overflow", rd, model_status());
    check("status_overflow_lit", rd, 32'hC004_8461);
    check("int_overflow", {31'h0, kp_int}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, 1'b1, 32'h0, rd);
      check("ev_multi", rd, model_pop());
    end
    check("ev_multi_last_lit", rd, 32'h0000_011A);
    wb_xfer(1'b0, 1'b1, 32'h0, rd);
    check("ev_empty", rd, model_pop());
    check("ev_empty_lit", rd, 32'h0);
    wb_xfer(1'b1, 1'b0, 32'hC000_0000, rd);
    m_ovf = 1'b0;
    wb_xfer(1'b0, 1'b0, 32'h0, rd);
    check("status_ovf_cleared", rd, model_status());
    check("status_ovf_cleared_lit", rd, 32'h4000_8461);

    // Reset in the middle of a scan with a key changing.
    keys = 16'h0001;
    cycles(10);
    rst_n = 1'b0;
    cycles(1);
    model_reset();
    check("midrst_col", {28'h0, kp_col}, 32'hf);
    check("midrst_int", {31'h0, kp_int}, 32'h0);
    rst_n = 1'b1;
    cycles(1);
    wb_xfer(1'b0, 1'b0, 32'h0, rd);
    check("midrst_status", rd, model_status());
    cycles(60);
    check("midrst_int_later", {31'h0, kp_int}, 32'h0);
    wb_xfer(1'b0, 1'b1, 32'h0, rd);
    check("midrst_fifo_empty", rd, model_pop());

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
